// File: rtl/level_controller.sv
// Multi-channel level controller: four debounced buttons select a channel and
// preset/step its level, with auto-repeat, saturation and hex display outputs.
module level_controller #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int DIV_BITS   = 20,
    parameter int HOLD_TICKS = 32,
    localparam int DIGITS    = (WIDTH + 3) / 4,
    localparam int SELW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [3:0]                key,
    output logic [CHANNELS*WIDTH-1:0] level,
    output logic [SELW-1:0]           sel,
    output logic [7*DIGITS-1:0]       display,
    output logic [6:0]                display_sel
);

    localparam int HOLDW = $clog2(HOLD_TICKS + 1);
    localparam int PADW  = 4 * DIGITS;
    localparam logic [WIDTH-1:0] LEVEL_MAX = {WIDTH{1'b1}};
    localparam logic [HOLDW-1:0] HOLD_LIMIT = HOLDW'(HOLD_TICKS);

    logic [3:0]          key_meta;
    logic [3:0]          key_sync;
    logic [DIV_BITS-1:0] div_cnt;
    logic                tick;
    logic [3:0]          sample;
    logic [3:0]          pressed;
    logic [3:0]          armed;
    logic [3:0]          pressed_next;
    logic [3:0]          press_evt;
    logic [HOLDW-1:0]    hold_cnt;
    logic [HOLDW-1:0]    hold_next;
    logic [WIDTH-1:0]    levels [CHANNELS];
    logic [WIDTH-1:0]    cur_level;
    logic [WIDTH-1:0]    new_level;
    logic                level_we;
    logic                sel_advance;
    logic                up_held;
    logic                down_held;
    logic                one_held;
    logic                step_now;
    logic [PADW-1:0]     cur_padded;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign tick = &div_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta <= '0;
            key_sync <= '0;
            div_cnt  <= '0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // Two matching low (high) tick samples are needed to change the debounced state.
    always_comb begin
        pressed_next = pressed;
        for (int k = 0; k < 4; k++) begin
            if (!sample[k] && !key_sync[k]) begin
                pressed_next[k] = 1'b1;
            end else if (sample[k] && key_sync[k]) begin
                pressed_next[k] = 1'b0;
            end
        end
        press_evt = {4{tick}} & pressed_next & ~pressed & armed;
    end

    // A key still held through reset stays inert until it has been seen released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample  <= '1;
            pressed <= '0;
            armed   <= '0;
        end else if (tick) begin
            sample  <= key_sync;
            pressed <= pressed_next;
            armed   <= armed | (~pressed_next & key_sync);
        end
    end

    always_comb begin
        cur_level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SELW'(i)) begin
                cur_level = levels[i];
            end
        end
    end

    always_comb begin
        up_held     = pressed_next[3] & armed[3];
        down_held   = pressed_next[2] & armed[2];
        one_held    = up_held ^ down_held;
        sel_advance = press_evt[0] & ~press_evt[1];
        step_now    = tick & one_held & ~press_evt[1] & ~press_evt[0] &
                      ((press_evt[3] | press_evt[2]) || (hold_cnt == HOLD_LIMIT));

        hold_next = hold_cnt;
        if (tick) begin
            if (!one_held || press_evt[1] || press_evt[0] || press_evt[3] || press_evt[2]) begin
                hold_next = '0;
            end else if (hold_cnt != HOLD_LIMIT) begin
                hold_next = hold_cnt + 1'b1;
            end
        end

        level_we  = 1'b0;
        new_level = cur_level;
        if (press_evt[1]) begin
            level_we  = 1'b1;
            new_level = LEVEL_MAX;
        end else if (step_now) begin
            level_we = 1'b1;
            if (up_held && cur_level != LEVEL_MAX) begin
                new_level = cur_level + 1'b1;
            end else if (down_held && cur_level != '0) begin
                new_level = cur_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            sel      <= '0;
        end else begin
            hold_cnt <= hold_next;
            if (sel_advance) begin
                if (sel == SELW'(CHANNELS - 1)) begin
                    sel <= '0;
                end else begin
                    sel <= sel + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                levels[i] <= LEVEL_MAX;
            end
        end else if (level_we) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SELW'(i)) begin
                    levels[i] <= new_level;
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_level_out
        assign level[i*WIDTH +: WIDTH] = levels[i];
    end

    // The top digit is zero-padded when WIDTH is not a multiple of four.
    always_comb begin
        cur_padded = PADW'(cur_level);
        display    = '0;
        for (int d = 0; d < DIGITS; d++) begin
            display[7*d +: 7] = hex7(cur_padded[4*d +: 4]);
        end
        display_sel = hex7(4'(sel));
    end

endmodule

// File: tb/tb_level_controller.sv
// Directed bench for level_controller with a fast tick (DIV_BITS=2) and a
// short hold (HOLD_TICKS=3); inputs change just after tick edges.
module tb_level_controller;

    localparam logic [3:0] K_NONE   = 4'b1111;
    localparam logic [3:0] K_SELECT = 4'b1110;
    localparam logic [3:0] K_PRESET = 4'b1101;
    localparam logic [3:0] K_DOWN   = 4'b1011;
    localparam logic [3:0] K_UP     = 4'b0111;
    localparam logic [3:0] K_BOTH   = 4'b0011;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  key;
    logic [31:0] level;
    logic [1:0]  sel;
    logic [13:0] display;
    logic [6:0]  display_sel;

    int assert_count = 0;
    int fail_count   = 0;

    level_controller #(
        .WIDTH(8),
        .CHANNELS(4),
        .DIV_BITS(2),
        .HOLD_TICKS(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key(key),
        .level(level),
        .sel(sel),
        .display(display),
        .display_sel(display_sel)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [3:0] k);
        key = k;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One tick is four clocks; every call ends on the negedge after a tick edge.
    task automatic waitTicks(input int n);
        repeat (4 * n) @(negedge clock);
    endtask

    task automatic tapKey(input logic [3:0] k);
        applyStimulus(k);
        waitTicks(2);
        applyStimulus(K_NONE);
        waitTicks(2);
    endtask

    initial begin
        $display("[TB] level_controller directed test starting");
        reset = 1'b1;
        applyStimulus(K_NONE);
        repeat (3) @(negedge clock);
        checkOutput("rst_level", level, 32'hFFFF_FFFF);
        checkOutput("rst_sel", {30'd0, sel}, 32'd0);
        checkOutput("rst_display", {18'd0, display}, {18'd0, SEG_F, SEG_F});
        checkOutput("rst_display_sel", {25'd0, display_sel}, {25'd0, SEG_0});
        reset = 1'b0;
        waitTicks(1);

        // Single press-and-release of down on channel 0.
        applyStimulus(K_DOWN);
        waitTicks(1);
        checkOutput("dn_before_event", level, 32'hFFFF_FFFF);
        waitTicks(1);
        checkOutput("dn_single_step", level, 32'hFFFF_FFFE);
        applyStimulus(K_NONE);
        waitTicks(6);
        checkOutput("dn_no_repeat", level, 32'hFFFF_FFFE);
        checkOutput("dn_display", {18'd0, display}, {18'd0, SEG_F, SEG_E});

        // Continuous down: step, three quiet ticks, then repeat down to zero.
        applyStimulus(K_DOWN);
        waitTicks(2);
        checkOutput("hold_press_step", level, 32'hFFFF_FFFD);
        waitTicks(3);
        checkOutput("hold_gap", level, 32'hFFFF_FFFD);
        waitTicks(1);
        checkOutput("repeat_first", level, 32'hFFFF_FFFC);
        waitTicks(1);
        checkOutput("repeat_second", level, 32'hFFFF_FFFB);
        waitTicks(250);
        checkOutput("repeat_one", level, 32'hFFFF_FF01);
        waitTicks(1);
        checkOutput("repeat_zero", level, 32'hFFFF_FF00);
        waitTicks(4);
        checkOutput("sat_zero_hold", level, 32'hFFFF_FF00);
        applyStimulus(K_NONE);
        waitTicks(3);

        // Channel select wraps 0,1,2,3,0,1.
        checkOutput("sel_start", {30'd0, sel}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tapKey(K_SELECT);
            checkOutput($sformatf("sel_tap%0d", i), {30'd0, sel}, i % 4);
        end
        checkOutput("sel_display", {25'd0, display_sel}, {25'd0, SEG_1});
        checkOutput("ch1_display", {18'd0, display}, {18'd0, SEG_F, SEG_F});

        // Up saturates on channel 1; down touches only channel 1.
        tapKey(K_UP);
        checkOutput("up_saturate_ch1", level, 32'hFFFF_FF00);
        tapKey(K_DOWN);
        checkOutput("dn_ch1_only", level, 32'hFFFF_FE00);

        // Up and down held together change nothing.
        applyStimulus(K_BOTH);
        waitTicks(10);
        checkOutput("both_hold", level, 32'hFFFF_FE00);
        applyStimulus(K_NONE);
        waitTicks(3);
        checkOutput("both_release", level, 32'hFFFF_FE00);

        // A low lasting one tick sample is not a press.
        applyStimulus(K_UP);
        waitTicks(1);
        applyStimulus(K_NONE);
        waitTicks(4);
        checkOutput("glitch_up", level, 32'hFFFF_FE00);

        tapKey(K_PRESET);
        checkOutput("preset_ch1", level, 32'hFFFF_FF00);

        // Reset in the middle of auto-repeat.
        applyStimulus(K_DOWN);
        waitTicks(2);
        checkOutput("rpt_press", level, 32'hFFFF_FE00);
        waitTicks(4);
        checkOutput("rpt_first", level, 32'hFFFF_FD00);
        waitTicks(1);
        checkOutput("rpt_before_reset", level, 32'hFFFF_FC00);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_level", level, 32'hFFFF_FFFF);
        checkOutput("async_reset_sel", {30'd0, sel}, 32'd0);
        checkOutput("async_reset_dsel", {25'd0, display_sel}, {25'd0, SEG_0});
        @(negedge clock);
        reset = 1'b0;
        waitTicks(1);
        waitTicks(8);
        checkOutput("held_after_reset", level, 32'hFFFF_FFFF);
        checkOutput("held_after_reset_sel", {30'd0, sel}, 32'd0);
        applyStimulus(K_NONE);
        waitTicks(3);
        applyStimulus(K_DOWN);
        waitTicks(2);
        checkOutput("fresh_press_after_reset", level, 32'hFFFF_FFFE);
        applyStimulus(K_NONE);
        waitTicks(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
